led_trail_fader: RTL

- Downstream stage of the 10-LED night-rider pattern generator. Consumes its 10-bit LED pattern and drives the physical LEDs.
- Each LED that drops out of the pattern fades out over time instead of switching off hard, which gives a KITT-style afterglow trail.
- Brightness is per-LED: a saturating decaying level register compared against a shared free-running PWM counter.

---
 rtl/led_trail_fader.sv | 109 ++++++++++
 1 files changed

// File: rtl/led_trail_fader.sv
// led_trail_fader: afterglow stage for the 10-LED night-rider pattern.
// Each LED holds a brightness level. The level loads to full while its
// pattern bit is set and then decays in steps on a slow tick once the bit
// clears. A shared free-running PWM counter turns each level into a duty cycle.
// Optional build macro LED_GAMMA_EN maps level L to a duty of floor(L*L/MAX)
// for a smoother perceived fade. Without it the duty is the level itself.
module led_trail_fader #(
  parameter int N_LEDS     = 10,
  parameter int PWM_BITS   = 4,
  parameter int DECAY_DIV  = 250000,
  parameter int DECAY_STEP = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_LEDS-1:0] pattern_in,
  output logic [N_LEDS-1:0] LED_out,
  output logic              decay_tick
);

  localparam int DIV_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int PROD_W = 2 * PWM_BITS;
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] level_q [N_LEDS];
  logic [PWM_BITS-1:0] level_d [N_LEDS];
  logic [PWM_BITS-1:0] duty    [N_LEDS];
  logic [N_LEDS-1:0]   led_q, led_d;
  logic                decay_tick_q, decay_tick_d;
  logic                tick;

  // Decay divider and PWM counter: both wrap at their last value.
  // pwm_cnt never reaches MAX, so a duty of MAX is always on.
  always_comb begin
    tick         = (div_cnt_q == DIV_LAST);
    div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
    pwm_cnt_d    = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    decay_tick_d = tick;
  end

  // Per-LED level: a set pattern bit reloads to MAX and wins over a tick.
  // A tick subtracts STEP only after the compare, so the level saturates at 0.
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      level_d[i] = level_q[i];
      if (pattern_in[i]) begin
        level_d[i] = MAX;
      end else if (tick) begin
        level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : '0;
      end
    end
  end

`ifdef LED_GAMMA_EN
  logic [PROD_W-1:0] sq [N_LEDS];

  // Gamma duty: floor(L*L/MAX) on a double-width product. The end points 0 and MAX map to themselves.
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      sq[i]   = PROD_W'(level_q[i]) * PROD_W'(level_q[i]);
      duty[i] = PWM_BITS'(sq[i] / PROD_W'(MAX));
    end
  end
`else
  // Linear duty: the level is used directly as the on-count per PWM period.
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      duty[i] = level_q[i];
    end
  end
`endif

  // PWM compare: an LED is on while the shared counter is below its duty.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      led_d[i] = (pwm_cnt_q < duty[i]);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      led_q        <= '0;
      decay_tick_q <= 1'b0;
      for (int i = 0; i < N_LEDS; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      div_cnt_q    <= div_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      led_q        <= led_d;
      decay_tick_q <= decay_tick_d;
      for (int i = 0; i < N_LEDS; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign LED_out    = led_q;
  assign decay_tick = decay_tick_q;

endmodule
